// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: evaluates B-type conditions and JAL/JALR, computes
// the redirect PC, flags mispredicts/misalignment and keeps saturating event counters.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter bit C_EXT = 1'b0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_kind,
   input  logic [2:0]       in_func3,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_imm,
   input  logic             in_pred_taken,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [XLEN-1:0]  out_next_pc,
   output logic             out_mispredict,
   output logic             out_misaligned,
   output logic             out_illegal,
   output logic [CNT_W-1:0] cnt_branch,
   output logic [CNT_W-1:0] cnt_taken,
   output logic [CNT_W-1:0] cnt_mispred
);

   typedef enum logic [1:0] {
      KIND_NONE   = 2'b00,
      KIND_BRANCH = 2'b01,
      KIND_JAL    = 2'b10,
      KIND_JALR   = 2'b11
   } kind_e;

   // Handshake: an op moves in when in_valid & in_ready & !flush; a result
   // leaves when out_valid & out_ready. in_ready is the only combinational
   // path (from out_ready); the output register is otherwise held stable.

   kind_e            kind;
   logic             rs_eq;
   logic             rs_lt;
   logic             rs_ltu;
   logic             br_cond;
   logic             res_illegal;
   logic             res_taken;
   logic             res_mispredict;
   logic             res_misaligned;
   logic             is_cti;
   logic [XLEN-1:0]  target_base;
   logic [XLEN-1:0]  target_sum;
   logic [XLEN-1:0]  target;
   logic [XLEN-1:0]  seq_pc;
   logic [XLEN-1:0]  res_next_pc;
   logic             accept;

   logic             out_valid_q,      out_valid_d;
   logic             out_taken_q,      out_taken_d;
   logic [XLEN-1:0]  out_next_pc_q,    out_next_pc_d;
   logic             out_mispredict_q, out_mispredict_d;
   logic             out_misaligned_q, out_misaligned_d;
   logic             out_illegal_q,    out_illegal_d;
   logic [CNT_W-1:0] cnt_branch_q,     cnt_branch_d;
   logic [CNT_W-1:0] cnt_taken_q,      cnt_taken_d;
   logic [CNT_W-1:0] cnt_mispred_q,    cnt_mispred_d;

   always_comb begin
      kind    = kind_e'(in_kind);
      rs_eq   = (in_rs1 == in_rs2);
      rs_lt   = ($signed(in_rs1) < $signed(in_rs2));
      rs_ltu  = (in_rs1 < in_rs2);
      br_cond     = 1'b0;
      res_illegal = 1'b0;
      case (in_func3)
         3'b000:  br_cond = rs_eq;
         3'b001:  br_cond = !rs_eq;
         3'b100:  br_cond = rs_lt;
         3'b101:  br_cond = !rs_lt;
         3'b110:  br_cond = rs_ltu;
         3'b111:  br_cond = !rs_ltu;
         default: res_illegal = (kind == KIND_BRANCH);
      endcase

      case (kind)
         KIND_BRANCH: res_taken = br_cond && !res_illegal;
         KIND_JAL,
         KIND_JALR:   res_taken = 1'b1;
         default:     res_taken = 1'b0;
      endcase

      // JALR adds to rs1 and drops bit 0; everything else is PC-relative.
      target_base = (kind == KIND_JALR) ? in_rs1 : in_pc;
      target_sum  = target_base + in_imm;
      target      = (kind == KIND_JALR) ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
      seq_pc      = in_pc + XLEN'(4);
      res_next_pc = res_taken ? target : seq_pc;

      res_mispredict = res_illegal ? 1'b0 : (res_taken != in_pred_taken);
      res_misaligned = res_taken && (C_EXT ? target[0] : (|target[1:0]));
      is_cti         = (kind != KIND_NONE);
   end

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      out_valid_d      = out_valid_q;
      out_taken_d      = out_taken_q;
      out_next_pc_d    = out_next_pc_q;
      out_mispredict_d = out_mispredict_q;
      out_misaligned_d = out_misaligned_q;
      out_illegal_d    = out_illegal_q;
      cnt_branch_d     = cnt_branch_q;
      cnt_taken_d      = cnt_taken_q;
      cnt_mispred_d    = cnt_mispred_q;

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d      = 1'b1;
         out_taken_d      = res_taken;
         out_next_pc_d    = res_next_pc;
         out_mispredict_d = res_mispredict;
         out_misaligned_d = res_misaligned;
         out_illegal_d    = res_illegal;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // Counters stick at all-ones instead of wrapping.
      if (accept && is_cti) begin
         if (cnt_branch_q != {CNT_W{1'b1}})
            cnt_branch_d = cnt_branch_q + CNT_W'(1);
         if (res_taken && (cnt_taken_q != {CNT_W{1'b1}}))
            cnt_taken_d = cnt_taken_q + CNT_W'(1);
         if (res_mispredict && (cnt_mispred_q != {CNT_W{1'b1}}))
            cnt_mispred_d = cnt_mispred_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q      <= 1'b0;
         out_taken_q      <= 1'b0;
         out_next_pc_q    <= '0;
         out_mispredict_q <= 1'b0;
         out_misaligned_q <= 1'b0;
         out_illegal_q    <= 1'b0;
         cnt_branch_q     <= '0;
         cnt_taken_q      <= '0;
         cnt_mispred_q    <= '0;
      end else begin
         out_valid_q      <= out_valid_d;
         out_taken_q      <= out_taken_d;
         out_next_pc_q    <= out_next_pc_d;
         out_mispredict_q <= out_mispredict_d;
         out_misaligned_q <= out_misaligned_d;
         out_illegal_q    <= out_illegal_d;
         cnt_branch_q     <= cnt_branch_d;
         cnt_taken_q      <= cnt_taken_d;
         cnt_mispred_q    <= cnt_mispred_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_taken      = out_taken_q;
   assign out_next_pc    = out_next_pc_q;
   assign out_mispredict = out_mispredict_q;
   assign out_misaligned = out_misaligned_q;
   assign out_illegal    = out_illegal_q;
   assign cnt_branch     = cnt_branch_q;
   assign cnt_taken      = cnt_taken_q;
   assign cnt_mispred    = cnt_mispred_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: two instances (32-bit align / 16-bit counters, and
// 16-bit align / 2-bit counters) share stimulus and are checked against a model.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [1:0]  in_kind;
   logic [2:0]  in_func3;
   logic [31:0] in_rs1, in_rs2, in_pc, in_imm;
   logic        in_pred_taken;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, out_taken_a, out_mispredict_a, out_misaligned_a, out_illegal_a;
   logic [31:0] out_next_pc_a;
   logic [15:0] cnt_branch_a, cnt_taken_a, cnt_mispred_a;
   logic        in_ready_b, out_valid_b, out_taken_b, out_mispredict_b, out_misaligned_b, out_illegal_b;
   logic [31:0] out_next_pc_b;
   logic [1:0]  cnt_branch_b, cnt_taken_b, cnt_mispred_b;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(32), .C_EXT(1'b0), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_kind(in_kind), .in_func3(in_func3), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_taken(out_taken_a),
      .out_next_pc(out_next_pc_a), .out_mispredict(out_mispredict_a),
      .out_misaligned(out_misaligned_a), .out_illegal(out_illegal_a),
      .cnt_branch(cnt_branch_a), .cnt_taken(cnt_taken_a), .cnt_mispred(cnt_mispred_a)
   );

   branch_resolve_unit #(.XLEN(32), .C_EXT(1'b1), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_kind(in_kind), .in_func3(in_func3), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_taken(out_taken_b),
      .out_next_pc(out_next_pc_b), .out_mispredict(out_mispredict_b),
      .out_misaligned(out_misaligned_b), .out_illegal(out_illegal_b),
      .cnt_branch(cnt_branch_b), .cnt_taken(cnt_taken_b), .cnt_mispred(cnt_mispred_b)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_valid;
   bit          m_taken, m_mis, m_ill, m_misal_a, m_misal_b;
   logic [31:0] m_npc;
   int          m_cnt_a[3];
   int          m_cnt_b[3];
   bit          check_on = 1'b0;

   function automatic void resolve(input logic [1:0] k, input logic [2:0] f3,
                                   input logic [31:0] rs1, rs2, pc, imm, input bit pred,
                                   output bit taken, output logic [31:0] npc, output bit mis,
                                   output bit ill, output bit misal32, output bit misal16);
      logic [31:0] tgt;
      taken = 0;
      ill   = 0;
      if (k == 2'd1) begin
         case (f3)
            3'd0: taken = (rs1 == rs2);
            3'd1: taken = (rs1 != rs2);
            3'd4: taken = ($signed(rs1) <  $signed(rs2));
            3'd5: taken = ($signed(rs1) >= $signed(rs2));
            3'd6: taken = (rs1 <  rs2);
            3'd7: taken = (rs1 >= rs2);
            default: ill = 1;
         endcase
      end else if (k != 2'd0) begin
         taken = 1;
      end
      tgt     = (k == 2'd3) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
      npc     = taken ? tgt : pc + 32'd4;
      mis     = ill ? 1'b0 : (taken != pred);
      misal32 = taken && (tgt % 4 != 0);
      misal16 = taken && (tgt % 2 != 0);
   endfunction

   function automatic int sat_inc(input int v, input int max);
      return (v < max) ? v + 1 : v;
   endfunction

   always @(posedge clk) begin
      bit t, mi, il, ma, mb, acc;
      logic [31:0] np;
      if (!rst_n) begin
         m_valid = 0; m_taken = 0; m_mis = 0; m_ill = 0; m_misal_a = 0; m_misal_b = 0; m_npc = 0;
         for (int i = 0; i < 3; i++) begin
            m_cnt_a[i] = 0;
            m_cnt_b[i] = 0;
         end
      end else begin
         acc = in_valid && (!m_valid || out_ready) && !flush;
         if (flush) begin
            m_valid = 0;
         end else if (acc) begin
            resolve(in_kind, in_func3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, t, np, mi, il, ma, mb);
            m_valid = 1; m_taken = t; m_npc = np; m_mis = mi; m_ill = il; m_misal_a = ma; m_misal_b = mb;
            if (in_kind != 2'd0) begin
               m_cnt_a[0] = sat_inc(m_cnt_a[0], 65535);
               m_cnt_b[0] = sat_inc(m_cnt_b[0], 3);
               if (t) begin
                  m_cnt_a[1] = sat_inc(m_cnt_a[1], 65535);
                  m_cnt_b[1] = sat_inc(m_cnt_b[1], 3);
               end
               if (mi) begin
                  m_cnt_a[2] = sat_inc(m_cnt_a[2], 65535);
                  m_cnt_b[2] = sat_inc(m_cnt_b[2], 3);
               end
            end
         end else if (out_ready) begin
            m_valid = 0;
         end
      end
   end

   // Per-cycle comparison on the falling edge.
   always @(negedge clk) begin
      if (check_on) begin
         chk("in_ready_a", in_ready_a, !m_valid || out_ready);
         chk("in_ready_b", in_ready_b, !m_valid || out_ready);
         chk("out_valid_a", out_valid_a, m_valid);
         chk("out_valid_b", out_valid_b, m_valid);
         chk("cnt_branch_a", cnt_branch_a, m_cnt_a[0]);
         chk("cnt_taken_a", cnt_taken_a, m_cnt_a[1]);
         chk("cnt_mispred_a", cnt_mispred_a, m_cnt_a[2]);
         chk("cnt_branch_b", cnt_branch_b, m_cnt_b[0]);
         chk("cnt_taken_b", cnt_taken_b, m_cnt_b[1]);
         chk("cnt_mispred_b", cnt_mispred_b, m_cnt_b[2]);
         if (m_valid) begin
            chk("taken_a", out_taken_a, m_taken);
            chk("taken_b", out_taken_b, m_taken);
            chk("next_pc_a", out_next_pc_a, m_npc);
            chk("next_pc_b", out_next_pc_b, m_npc);
            chk("mispredict_a", out_mispredict_a, m_mis);
            chk("mispredict_b", out_mispredict_b, m_mis);
            chk("illegal_a", out_illegal_a, m_ill);
            chk("illegal_b", out_illegal_b, m_ill);
            chk("misaligned_a", out_misaligned_a, m_misal_a);
            chk("misaligned_b", out_misaligned_b, m_misal_b);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_op(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                         input bit pred);
      in_valid = 1'b1; in_kind = k; in_func3 = f3; in_rs1 = rs1; in_rs2 = rs2;
      in_pc = pc; in_imm = imm; in_pred_taken = pred;
   endtask

   // Entered at posedge+2; returns at posedge+2 right after the accepting edge.
   task automatic send(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm,
                       input bit pred);
      int  guard = 0;
      bit  ok;
      set_op(k, f3, rs1, rs2, pc, imm, pred);
      do begin
         #3;
         ok = in_ready_a && !flush;
         @(posedge clk);
         #2;
         guard++;
      end while (!ok && guard < 50);
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic idle(input int cycles);
      in_valid = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #2;
      end
   endtask

   int snap[3];

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b0; in_kind = 2'd0; in_func3 = 3'd0;
      in_rs1 = 0; in_rs2 = 0; in_pc = 0; in_imm = 0; in_pred_taken = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_out_valid", out_valid_a, 0);
      chk("rst_next_pc", out_next_pc_a, 0);
      chk("rst_taken", out_taken_a, 0);
      chk("rst_cnt_branch", cnt_branch_a, 0);
      chk("rst_cnt_b_taken", cnt_taken_b, 0);
      chk("rst_in_ready", in_ready_a, 1);
      rst_n = 1'b1;
      check_on = 1'b1;
      idle(1);

      // Signed vs unsigned compares
      send(2'd1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
      chk("blt_taken", out_taken_a, 1);
      chk("blt_next_pc", out_next_pc_a, 32'h120);
      chk("blt_mispredict", out_mispredict_a, 1);
      send(2'd1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
      chk("bltu_taken", out_taken_a, 0);
      chk("bltu_next_pc", out_next_pc_a, 32'h104);
      send(2'd1, 3'b101, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
      chk("bge_eq_taken", out_taken_a, 1);
      idle(1);

      // JALR with odd base: bit 0 dropped, bit 1 left set
      send(2'd3, 3'd0, 32'h1003, 32'd0, 32'h200, 32'd0, 1'b1);
      chk("jalr_next_pc", out_next_pc_a, 32'h1002);
      chk("jalr_misal_32", out_misaligned_a, 1);
      chk("jalr_misal_16", out_misaligned_b, 0);
      idle(1);

      // Assorted vectors checked only by the model
      send(2'd1, 3'b000, 32'h55, 32'h55, 32'h400, 32'hFFFF_FFF0, 1'b1);
      send(2'd1, 3'b001, 32'h55, 32'h55, 32'h400, 32'h40, 1'b1);
      send(2'd1, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h500, 32'h10, 1'b0);
      send(2'd2, 3'd0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20, 1'b1);
      chk("jal_wrap_next_pc", out_next_pc_a, 32'h10);
      send(2'd0, 3'd0, 32'd0, 32'd0, 32'h40, 32'h8, 1'b0);
      chk("none_next_pc", out_next_pc_a, 32'h44);
      send(2'd2, 3'd0, 32'd0, 32'd0, 32'h100, 32'h6, 1'b1);
      send(2'd2, 3'd0, 32'd0, 32'd0, 32'h100, 32'h5, 1'b1);
      chk("jal_odd_misal_16", out_misaligned_b, 1);
      idle(2);

      // Backpressure: result held, in_ready low, then streaming
      out_ready = 1'b0;
      send(2'd2, 3'd0, 32'd0, 32'd0, 32'h600, 32'h40, 1'b1);
      set_op(2'd1, 3'b000, 32'd1, 32'd2, 32'h700, 32'h80, 1'b0);
      repeat (3) begin
         #3;
         chk("stall_in_ready", in_ready_a, 0);
         chk("stall_hold_pc", out_next_pc_a, 32'h640);
         @(posedge clk);
         #2;
      end
      out_ready = 1'b1;
      send(2'd1, 3'b000, 32'd1, 32'd2, 32'h700, 32'h80, 1'b0);
      chk("release_next_pc", out_next_pc_a, 32'h704);
      send(2'd1, 3'b001, 32'd1, 32'd2, 32'h800, 32'h80, 1'b0);
      send(2'd3, 3'd0, 32'h2000, 32'd0, 32'h900, 32'h11, 1'b0);
      chk("stream_jalr_pc", out_next_pc_a, 32'h2010);
      idle(2);

      // Flush with a held result and an offered op
      out_ready = 1'b0;
      send(2'd2, 3'd0, 32'd0, 32'd0, 32'hA00, 32'h4, 1'b0);
      for (int i = 0; i < 3; i++) snap[i] = m_cnt_a[i];
      set_op(2'd2, 3'd0, 32'd0, 32'd0, 32'hB00, 32'h4, 1'b0);
      flush = 1'b1;
      @(posedge clk);
      #2;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", out_valid_a, 0);
      chk("flush_cnt_branch", cnt_branch_a, snap[0]);
      chk("flush_cnt_taken", cnt_taken_a, snap[1]);
      chk("flush_cnt_mispred", cnt_mispred_a, snap[2]);
      out_ready = 1'b1;
      idle(1);

      // Saturation on the 2-bit counters, then an illegal func3
      repeat (5) send(2'd2, 3'd0, 32'd0, 32'd0, 32'h300, 32'h8, 1'b0);
      chk("sat_cnt_branch_b", cnt_branch_b, 3);
      chk("sat_cnt_taken_b", cnt_taken_b, 3);
      chk("sat_cnt_mispred_b", cnt_mispred_b, 3);
      send(2'd1, 3'b011, 32'd7, 32'd7, 32'h300, 32'h8, 1'b1);
      chk("illegal_flag", out_illegal_a, 1);
      chk("illegal_taken", out_taken_a, 0);
      chk("illegal_mispredict", out_mispredict_a, 0);
      chk("illegal_next_pc", out_next_pc_a, 32'h304);
      idle(3);

      check_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
